// File: rtl/rv32i_types.sv
// Shared RV32 type package: word type, M-extension funct3 encodings,
// and the iterative multiply/divide unit's constants and FSM states.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_funct3_t;

  localparam int MULDIV_ITERS = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps on
// operand magnitudes, sign fix-up on the final step, one-cycle done pulse.
module muldiv_unit
  import rv32i_types::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  muldiv_funct3_t funct3,
  input  rv32i_word      a,
  input  rv32i_word      b,
  output logic           busy,
  output logic           done,
  output rv32i_word      result
);

  localparam int CNT_W = $clog2(MULDIV_ITERS);

  muldiv_state_t  state, state_next;
  logic [CNT_W-1:0] cnt;
  muldiv_funct3_t op;
  logic           neg_res, neg_rem;
  rv32i_word      acc, sh, b_reg;

  // Request decode, evaluated on the live inputs while IDLE.
  logic      a_neg, b_neg, is_div, is_rem, div_zero, div_ovf, special;
  rv32i_word a_mag, b_mag, special_res;

  always_comb begin
    a_neg       = (funct3 != MULHU) && (funct3 != DIVU) && (funct3 != REMU) && a[31];
    b_neg       = (funct3 inside {MUL, MULH, DIV, REM}) && b[31];
    a_mag       = a_neg ? -a : a;
    b_mag       = b_neg ? -b : b;
    is_div      = funct3[2];
    is_rem      = funct3[1];
    div_zero    = is_div && (b == '0);
    div_ovf     = (funct3 inside {DIV, REM}) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special     = div_zero || div_ovf;
    if (div_zero) special_res = is_rem ? a : 32'hFFFF_FFFF;
    else          special_res = is_rem ? 32'h0 : 32'h8000_0000;
  end

  // One iteration. Multiply keeps {acc, sh} as the shifting product with the
  // multiplier in sh; divide keeps the partial remainder in acc and shifts
  // dividend bits out of sh while quotient bits shift in.
  logic [32:0] mul_sum, trial, diff;
  rv32i_word   acc_nx, sh_nx, fin_res;
  logic [63:0] prod;

  always_comb begin
    mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, b_reg} : 33'd0);
    trial   = {acc, sh[31]};
    diff    = trial - {1'b0, b_reg};
    if (op[2]) begin
      acc_nx = diff[32] ? trial[31:0] : diff[31:0];
      sh_nx  = {sh[30:0], ~diff[32]};
    end else begin
      acc_nx = mul_sum[32:1];
      sh_nx  = {mul_sum[0], sh[31:1]};
    end
    prod = neg_res ? -{acc_nx, sh_nx} : {acc_nx, sh_nx};
    case (op)
      MUL:               fin_res = prod[31:0];
      MULH, MULHSU, MULHU: fin_res = prod[63:32];
      DIV, DIVU:         fin_res = neg_res ? -sh_nx : sh_nx;
      default:           fin_res = neg_rem ? -acc_nx : acc_nx;
    endcase
  end

  // NOTE: every combinational output is given a default before any branch so
  // no path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = special ? DONE : CALC;
      CALC: if (cnt == CNT_W'(MULDIV_ITERS - 1)) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op      <= MUL;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      acc     <= '0;
      sh      <= '0;
      b_reg   <= '0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          neg_res <= a_neg ^ b_neg;
          neg_rem <= a_neg;
          acc     <= '0;
          sh      <= a_mag;
          b_reg   <= b_mag;
          cnt     <= '0;
          if (special) result <= special_res;
        end
        CALC: begin
          acc <= acc_nx;
          sh  <= sh_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MULDIV_ITERS - 1)) result <= fin_res;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
